aes_inv_cipher_iter: RTL
========================

Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher (decryption datapath): one ciphertext block in, one plaintext block out, one round per clock.
- Counterpart of the encrypt round engine. Reuses the same 128-bit state byte ordering, so the existing ShiftRows/InvShiftRows lane mapping carries over unchanged.
- Sits between the decrypt-side input FIFO and the output buffer.
- Round keys come from the shared key store via an index/data lookup.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values unsupported).
- RKIW, 4, width of round-key index.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  ciphertext block valid.
- in_ready  output  1  block can be accepted.
- ct_in  input  128  ciphertext block.
- rk_idx  output  RKIW  round-key index requested (0..NR).
- rk_in  input  128  round key for rk_idx; combinational from the key store, same cycle.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- pt_out  output  128  plaintext block.
- busy  output  1  block in flight (state != IDLE).

Behaviour:
- State byte order: state[r][c] = bus[8*(4c+r)+7 : 8*(4c+r)]. Byte 0 (row0, col0) is at the LSB. This applies to ct_in, rk_in and pt_out.
- FSM states: IDLE, ROUND, FINAL, DONE.
- Reset values: state IDLE; st_reg 0; rnd 0; in_ready 1; out_valid 0; pt_out 0; busy 0; rk_idx NR.
- IDLE:
  - rk_idx = NR; in_ready = 1.
  - On in_valid: st_reg <= ct_in ^ rk_in; rnd <= NR-1; go to ROUND.
- ROUND:
  - rk_idx = rnd.
  - st_reg <= InvMixColumns(InvSubBytes(InvShiftRows(st_reg)) ^ rk_in).
  - rnd decrements each cycle. When rnd == 1 (last ROUND cycle), go to FINAL. Nine ROUND cycles in total.
- FINAL:
  - rk_idx = 0.
  - st_reg <= InvSubBytes(InvShiftRows(st_reg)) ^ rk_in; go to DONE.
- DONE:
  - out_valid = 1; pt_out = st_reg.
  - Hold pt_out stable until out_ready. On out_valid && out_ready, go to IDLE.
- Latency: out_valid rises on the 11th rising edge after the accept edge (1 accept + 9 ROUND + 1 FINAL). Throughput is one block per 12 cycles minimum.
- in_ready is 1 only in IDLE. in_valid in any other state is ignored and ct_in is not sampled.
- Backpressure: out_ready low in DONE holds out_valid, pt_out and rk_idx indefinitely.
- out_ready high outside DONE has no effect.
- Reset mid-operation: return to IDLE immediately (asynchronous). The in-flight block is discarded and out_valid does not pulse.
- InvShiftRows: row r rotates right by r columns.
- InvMixColumns:
  - Per column, multiply by the matrix {0e,0b,0d,09} over GF(2^8) with poly 0x11b.
  - Build from xtime chains; no multipliers.
- rk_idx is registered-state derived (a decode of state and rnd), so it is glitch-free relative to the key store read.

Decomposition:
- aes_pkg (shared with the encrypt side):
  - state typedef (4x4 bytes) and byte-index function bidx(r,c) = 4c+r;
  - xtime and gmul functions;
  - NR constant;
  - FSM enum.
- Sub-module aes_inv_sbox: 8-bit combinational inverse S-box table, instantiated 16 times.
- InvShiftRows and InvMixColumns are package functions, not separate modules.

Test Plan:
- FIPS-197 C.1 key 000102..0f, bench-driven key store.
  - Stimulus: ct_in = 128'h5ac5b47080b7cdd830047b6ad8e0c469.
  - Required: pt_out = 128'hffeeddccbbaa99887766554433221100, out_valid 11 edges after accept.
- Zero key.
  - Stimulus: ct_in = 128'h2e2b34ca59fa4c883b2c8aefd44be966.
  - Required: pt_out = 0.
  - Required: rk_idx sequence 10,9,...,1,0 across the accept/ROUND/FINAL cycles.
- Backpressure.
  - Stimulus: hold out_ready = 0 for 20 cycles after out_valid.
  - Required: out_valid, pt_out and rk_idx = 0 stable, and in_ready = 0 throughout.
  - Then out_ready = 1 for 1 cycle. Required: IDLE and in_ready = 1 next cycle.
- Busy ignore.
  - Stimulus: pulse in_valid with a different ct_in during ROUND.
  - Required: no effect; the C.1 result is still correct.
- Reset mid-operation.
  - Stimulus: assert rst_n = 0 at ROUND cycle 4 (asynchronous, between edges).
  - Required: in_ready = 1, out_valid = 0, pt_out = 0 immediately.
  - Then a fresh C.1 block decrypts correctly.
- Back-to-back.
  - Stimulus: two blocks (C.1, then zero-key vector with keys swapped by the bench).
  - Required: both correct; second accept edge no earlier than 1 cycle after first out handshake.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES definitions: state layout, byte indexing, GF(2^8)
//               helpers, FSM encoding and the InvShiftRows / InvMixColumns
//               transforms used by the iterative decrypt datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // AES-128 round count.
  localparam int NR = 10;

  // 16 bytes; element i occupies bus bits [8i+7:8i], with i = 4*col + row.
  typedef logic [15:0][7:0] state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } fsm_e;

  // Byte position of state[r][c] inside the 128-bit bus (4c + r).
  function automatic logic [3:0] bidx(input logic [1:0] r, input logic [1:0] c);
    return {c, r};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using an xtime chain (covers 09/0b/0d/0e).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][c - r].
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[bidx(2'(r), 2'(c))] = s[bidx(2'(r), 2'(c - r))];
      end
    end
    return o;
  endfunction

  // Per-column multiply by the circulant matrix {0e,0b,0d,09}.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t     o;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[bidx(2'd0, 2'(c))];
      a1 = s[bidx(2'd1, 2'(c))];
      a2 = s[bidx(2'd2, 2'(c))];
      a3 = s[bidx(2'd3, 2'(c))];
      o[bidx(2'd0, 2'(c))] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[bidx(2'd1, 2'(c))] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[bidx(2'd2, 2'(c))] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[bidx(2'd3, 2'(c))] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_sbox
// Description : Combinational AES inverse S-box (8-bit table lookup).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] c_inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_o = c_inv_sbox[in_i];

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_cipher_iter
// Description : Iterative AES-128 inverse cipher, one round per clock.
//               Accept cycle applies the last round key, nine full rounds
//               follow, then a final round without InvMixColumns. Round keys
//               are fetched combinationally from the key store via rk_idx_o.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_iter #(
  parameter int NR   = aes_pkg::NR,
  parameter int RKIW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [127:0]    ct_in_i,
  output logic [RKIW-1:0] rk_idx_o,
  input  logic [127:0]    rk_in_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [127:0]    pt_out_o,
  output logic            busy_o
);

  import aes_pkg::*;

  localparam logic [RKIW-1:0] c_idx_last  = RKIW'(NR);
  localparam logic [RKIW-1:0] c_idx_first = RKIW'(NR - 1);
  localparam logic [RKIW-1:0] c_idx_one   = RKIW'(1);

  fsm_e            state_q;
  fsm_e            state_d;
  state_t          st_q;
  state_t          st_d;
  logic [RKIW-1:0] rnd_q;
  logic [RKIW-1:0] rnd_d;

  state_t          w_isr;
  state_t          w_isb;
  state_t          w_ark;

  // Shared round front-end: InvShiftRows -> InvSubBytes -> AddRoundKey.
  assign w_isr = inv_shift_rows(st_q);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      aes_inv_sbox u_sbox (
        .in_i  (w_isr[gi]),
        .out_o (w_isb[gi])
      );
    end
  endgenerate

  assign w_ark = w_isb ^ rk_in_i;

  // State, round counter and datapath registers; async reset drops any in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

  // Next-state, datapath update and output decode from the registered state.
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rnd_d       = rnd_q;
    rk_idx_o    = c_idx_last;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    pt_out_o    = '0;
    busy_o      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_o     = 1'b0;
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          st_d    = ct_in_i ^ rk_in_i;
          rnd_d   = c_idx_first;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_idx_o = rnd_q;
        st_d     = inv_mix_columns(w_ark);
        rnd_d    = rnd_q - c_idx_one;
        if (rnd_q == c_idx_one) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        rk_idx_o = '0;
        st_d     = w_ark;
        state_d  = S_DONE;
      end
      S_DONE: begin
        rk_idx_o    = '0;
        out_valid_o = 1'b1;
        pt_out_o    = st_q;
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
